// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays out a change amount coin by coin, largest denomination first
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [CNT_W-1:0] load_count,
    output logic             eject_valid,
    output logic [2:0]       eject_code,
    input  logic             eject_done,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain,
    output logic             busy,
    output logic [CNT_W-1:0] stock5,
    output logic [CNT_W-1:0] stock10,
    output logic [CNT_W-1:0] stock20
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_EJECT  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_5    = 3'b001;
    localparam logic [2:0] CODE_10   = 3'b010;
    localparam logic [2:0] CODE_20   = 3'b011;

    localparam logic [AMT_W-1:0] DEN5    = AMT_W'(5);
    localparam logic [AMT_W-1:0] DEN10   = AMT_W'(10);
    localparam logic [AMT_W-1:0] DEN20   = AMT_W'(20);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q,   state_d;
    logic [AMT_W-1:0] remain_q,  remain_d;
    logic             short_q,   short_d;
    logic [2:0]       code_q,    code_d;
    logic [CNT_W-1:0] stock5_q,  stock5_d;
    logic [CNT_W-1:0] stock10_q, stock10_d;
    logic [CNT_W-1:0] stock20_q, stock20_d;
    logic [AMT_W-1:0] denom;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            short_q   <= 1'b0;
            code_q    <= CODE_NONE;
            stock5_q  <= '0;
            stock10_q <= '0;
            stock20_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            short_q   <= short_d;
            code_q    <= code_d;
            stock5_q  <= stock5_d;
            stock10_q <= stock10_d;
            stock20_q <= stock20_d;
        end
    end

    always_comb begin
        case (code_q)
            CODE_20: denom = DEN20;
            CODE_10: denom = DEN10;
            default: denom = DEN5;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        short_d   = short_q;
        code_d    = code_q;
        stock5_d  = stock5_q;
        stock10_d = stock10_q;
        stock20_d = stock20_q;
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    case (load_sel)
                        2'd0:    stock5_d  = load_count;
                        2'd1:    stock10_d = load_count;
                        2'd2:    stock20_d = load_count;
                        default: ;
                    endcase
                end
                if (req_valid) begin
                    remain_d = req_amount;
                    short_d  = 1'b0;
                    state_d  = S_SELECT;
                end
            end
            // Both checks guard the subsequent subtractions against wrap.
            S_SELECT: begin
                if (remain_q == '0) begin
                    short_d = 1'b0;
                    state_d = S_FINISH;
                end else if ((stock20_q != '0) && (remain_q >= DEN20)) begin
                    code_d  = CODE_20;
                    state_d = S_EJECT;
                end else if ((stock10_q != '0) && (remain_q >= DEN10)) begin
                    code_d  = CODE_10;
                    state_d = S_EJECT;
                end else if ((stock5_q != '0) && (remain_q >= DEN5)) begin
                    code_d  = CODE_5;
                    state_d = S_EJECT;
                end else begin
                    short_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_EJECT: begin
                if (eject_done) begin
                    remain_d = remain_q - denom;
                    case (code_q)
                        CODE_20: stock20_d = stock20_q - CNT_ONE;
                        CODE_10: stock10_d = stock10_q - CNT_ONE;
                        default: stock5_d  = stock5_q - CNT_ONE;
                    endcase
                    state_d = S_SELECT;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        eject_valid = (state_q == S_EJECT);
        eject_code  = (state_q == S_EJECT) ? code_q : CODE_NONE;
        done        = (state_q == S_FINISH);
        short       = short_q;
        remain      = remain_q;
        stock5      = stock5_q;
        stock10     = stock10_q;
        stock20     = stock20_q;
    end

endmodule
`default_nettype wire
